// File: rtl/rotation_slice_timer.sv
// rotation_slice_timer
//   Derives the current image row (angular slice) of the rotating voxel display from a
//   once-per-revolution index sensor and a multi-mark magnetic encoder. The revolution period
//   is measured in clk cycles and turned into an exact fixed-point row step, so rows are
//   interpolated without accumulated rounding drift. A phase offset is added to the row, and a
//   req/ack handshake tells the consumer about row changes and counts the ones it missed.
//
// Ports
//   clk          clock
//   nReset       synchronous, active-low reset
//   mag_in       asynchronous encoder sensor
//   index_in     asynchronous index sensor, rising edge = revolution start
//   row_offset   phase offset added to the row (quasi-static)
//   row          current row, (raw_row + row_offset) mod NUM_ROWS
//   valid        high only while locked
//   index_pulse  one-cycle pulse at each revolution start while locked
//   row_req      row changed, waiting for row_ack
//   row_ack      consumer has taken the row
//   missed_cnt   row changes lost while row_req was pending, saturating
//   period       last accepted revolution period in clk cycles
module rotation_slice_timer #(
    parameter int unsigned CLK_FREQ    = 90_000_000,
    parameter int unsigned MIN_RPS     = 5,
    parameter int unsigned NUM_MARKS   = 720,
    parameter int unsigned NUM_ROWS    = 256,
    parameter int unsigned FRAC_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 0,
    localparam int unsigned TIMEOUT    = CLK_FREQ / MIN_RPS,
    localparam int unsigned RW         = $clog2(NUM_ROWS),
    localparam int unsigned CW         = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          mag_in,
    input  logic          index_in,
    input  logic [RW-1:0] row_offset,
    output logic [RW-1:0] row,
    output logic          valid,
    output logic          index_pulse,
    output logic          row_req,
    input  logic          row_ack,
    output logic [7:0]    missed_cnt,
    output logic [CW-1:0] period
);

    localparam int unsigned MW = $clog2(2 * NUM_MARKS + 1);
    localparam int unsigned FW = CW + FRAC_BITS;

    typedef enum logic [1:0] {StUnsync, StAcquire, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] mag_sync_q, idx_sync_q;
    logic                   mag_hist_q, idx_hist_q;
    logic [CW-1:0]          rev_cnt_q, rev_cnt_d;
    logic [MW-1:0]          mark_cnt_q, mark_cnt_d;
    logic [FW-1:0]          step_q, step_d;
    logic [FW-1:0]          acc_q, acc_d;
    logic [RW-1:0]          raw_q, raw_d;
    logic [RW-1:0]          row_q, row_d;
    logic                   pulse_q, pulse_d;
    logic                   req_q, req_d;
    logic [7:0]             miss_q, miss_d;
    logic [CW-1:0]          period_q, period_d;

    logic                   idx_ev, mag_ev, mag_s, idx_s;
    logic [CW-1:0]          period_meas;
    logic                   rev_good, timeout, load;
    logic [FW-1:0]          p_wide, acc_sum;

    assign mag_s  = mag_sync_q[SYNC_STAGES-1];
    assign idx_s  = idx_sync_q[SYNC_STAGES-1];
    assign idx_ev = idx_s & ~idx_hist_q;
    assign mag_ev = (EDGE_MODE != 0) ? (mag_s & ~mag_hist_q) : (mag_s ^ mag_hist_q);

    always_comb begin
        period_meas = rev_cnt_q + CW'(1);
        rev_good    = (mark_cnt_q == MW'(NUM_MARKS)) && (period_meas >= CW'(NUM_ROWS));
        timeout     = (rev_cnt_q == CW'(TIMEOUT - 1));

        state_d = state_q;
        case (state_q)
            StUnsync:  if (idx_ev) state_d = StAcquire;
            StAcquire: begin
                if (idx_ev) begin
                    if (rev_good) state_d = StLocked;
                end else if (timeout) begin
                    state_d = StUnsync;
                end
            end
            StLocked: begin
                if (idx_ev) begin
                    if (!rev_good) state_d = StAcquire;
                end else if (timeout) begin
                    state_d = StUnsync;
                end
            end
            default: state_d = StUnsync;
        endcase

        // Measurement counters restart on every index edge regardless of state.
        if (idx_ev) begin
            rev_cnt_d = '0;
        end else if (rev_cnt_q == CW'(TIMEOUT)) begin
            rev_cnt_d = rev_cnt_q;
        end else begin
            rev_cnt_d = rev_cnt_q + CW'(1);
        end
        mark_cnt_d = idx_ev ? '0 : mark_cnt_q;
        if (mag_ev && (mark_cnt_d != MW'(2 * NUM_MARKS))) mark_cnt_d = mark_cnt_d + MW'(1);

        // Step is P * 2^FRAC_BITS / NUM_ROWS; NUM_ROWS is a power of two so this is exact.
        load     = idx_ev && (state_d == StLocked);
        p_wide   = {{FRAC_BITS{1'b0}}, period_meas};
        step_d   = load ? ((p_wide << FRAC_BITS) >> RW) : step_q;
        period_d = load ? period_meas : period_q;

        // Rows advance while locked; an index edge restarts at row 0 and the new step
        // takes effect from the following cycle.
        acc_sum = acc_q + (FW'(1) << FRAC_BITS);
        acc_d   = '0;
        raw_d   = '0;
        if (state_d == StLocked && !idx_ev) begin
            acc_d = acc_sum;
            raw_d = raw_q;
            if (acc_sum >= step_q) begin
                acc_d = acc_sum - step_q;
                if (raw_q != RW'(NUM_ROWS - 1)) raw_d = raw_q + RW'(1);
            end
        end

        row_d   = raw_d + row_offset;
        pulse_d = load;

        req_d  = req_q;
        miss_d = miss_q;
        if (state_d != StLocked) begin
            req_d = 1'b0;
        end else if (raw_d != raw_q) begin
            req_d = 1'b1;
            if (req_q && !row_ack && (miss_q != 8'hFF)) miss_d = miss_q + 8'd1;
        end else if (row_ack) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q    <= StUnsync;
            mag_sync_q <= '0;
            idx_sync_q <= '0;
            mag_hist_q <= 1'b0;
            idx_hist_q <= 1'b0;
            rev_cnt_q  <= '0;
            mark_cnt_q <= '0;
            step_q     <= '0;
            acc_q      <= '0;
            raw_q      <= '0;
            row_q      <= row_offset;
            pulse_q    <= 1'b0;
            req_q      <= 1'b0;
            miss_q     <= '0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            mag_sync_q <= {mag_sync_q[SYNC_STAGES-2:0], mag_in};
            idx_sync_q <= {idx_sync_q[SYNC_STAGES-2:0], index_in};
            mag_hist_q <= mag_s;
            idx_hist_q <= idx_s;
            rev_cnt_q  <= rev_cnt_d;
            mark_cnt_q <= mark_cnt_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            raw_q      <= raw_d;
            row_q      <= row_d;
            pulse_q    <= pulse_d;
            req_q      <= req_d;
            miss_q     <= miss_d;
            period_q   <= period_d;
        end
    end

    assign row         = row_q;
    assign valid       = (state_q == StLocked);
    assign index_pulse = pulse_q;
    assign row_req     = req_q;
    assign missed_cnt  = miss_q;
    assign period      = period_q;

endmodule
